cpu_press_ctrl: RTL and testbench
=================================

# cpu_press_ctrl

Sequencing controller for the computer player's button-press decision. It paces the `SW + Q` overflow test (difficulty switches plus LFSR random value) to one evaluation every `PERIOD` cycles and turns each hit into a single-cycle `press` pulse. After each press it enforces a fixed cooldown and keeps a saturating press count. It sits between the LFSR / difficulty switches and the game logic that consumes the computer's button.

## Interface
- `PERIOD`, default 16: cycles spent in WAIT between evaluations; must be ≥ 2.
- `COOL_CYCLES`, default 32: cycles spent in COOL after each press; must be ≥ 1.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  game running; low forces IDLE.
- `Q`  in  9  random value from the LFSR.
- `SW`  in  9  difficulty setting.
- `clear`  in  1  synchronous clear of `press_count` only.
- `press`  out  1  one-cycle computer button press.
- `busy`  out  1  high while in PRESS or COOL.
- `press_count`  out  8  presses since reset/clear, saturating at 255.

## Operation
- States: IDLE, WAIT, EVAL, PRESS, COOL. Outputs are decoded from registered state:
  - `press` = (state == PRESS)
  - `busy` = (state == PRESS or COOL)
- Enable gating:
  - Any state with `enable` = 0 goes to IDLE on the next edge. Interval and cooldown counters clear to 0.
  - A PRESS cycle already in progress still completes as one cycle.
- IDLE: when `enable` = 1, go to WAIT with the interval counter at 0.
- WAIT: the interval counter increments each cycle. On the cycle the counter equals `PERIOD`−1, go to EVAL.
- EVAL (one cycle): compute the 10-bit `sum = {1'b0,SW} + {1'b0,Q}`; `hit = sum[9]`, i.e. `Q + SW ≥ 512`.
  - `hit` = 1: go to PRESS.
  - `hit` = 0: go to WAIT with the counter at 0.
  - `Q` and `SW` are sampled only on the EVAL edge; values in other cycles are ignored.
- PRESS (one cycle): go to COOL with the cooldown counter at 0. `press_count` increments on the edge entering PRESS, saturating at 255.
- COOL: the cooldown counter increments each cycle. On the cycle it equals `COOL_CYCLES`−1, go to WAIT with the counter at 0.
- Arithmetic boundaries:
  - No truncation: `SW` = 0 never hits, because `Q` ≤ 511.
  - `SW` = 511 hits for every `Q` ≥ 1.
- `clear` = 1: `press_count` becomes 0 on the next edge. `clear` wins over a simultaneous increment. The FSM is unaffected.
- `reset` = 1: overrides everything, including mid-WAIT, mid-COOL or during PRESS. On the next edge:
  - State = IDLE, both counters = 0.
  - `press` = 0, `busy` = 0, `press_count` = 0.

## Timing
- Reset values: `press` 0, `busy` 0, `press_count` 0, state IDLE.
- Let edge E0 be the edge that first samples `enable` = 1 in IDLE:
  - WAIT occupies cycles 1..`PERIOD`.
  - EVAL is cycle `PERIOD`+1.
  - PRESS is cycle `PERIOD`+2, so `press` is high in cycle 18 at defaults.
- Press-to-press spacing with continuous hits is `COOL_CYCLES` + `PERIOD` + 2 cycles (50 at defaults).
- `busy` is high for 1 + `COOL_CYCLES` consecutive cycles per press.
- `press_count` reflects a new press in the same cycle `press` is high.
- Dropping `enable` removes `busy` one cycle later. Re-enabling restarts the full `PERIOD`+2 latency; there is no partial-interval carry-over.

## Test plan
- Reset / idle:
  - Stimulus: hold `reset` for 2 cycles, then `enable` = 0 for 100 cycles with `SW` = 511, `Q` = 511.
  - Required: `press` = 0, `busy` = 0 and `press_count` = 0 throughout.
- First-press latency:
  - Stimulus: `SW` = 2, `Q` = 510, raise `enable`.
  - Required: `press` high exactly in cycle 18 after E0, for one cycle.
  - Required: `press_count` = 1; `busy` high in cycles 18..50.
- Compare boundary:
  - `SW` = 2, `Q` = 509 (sum 511) → no press over 500 cycles.
  - Changing to `Q` = 510 → press at the next EVAL.
  - `SW` = 0, `Q` = 511 → never presses.
- Cooldown spacing:
  - Stimulus: `SW` = 511, `Q` = 511 held constant.
  - Required: successive presses exactly 50 cycles apart; `Q` = 0 with `SW` = 511 gives no press.
- Enable / reset mid-operation:
  - Drop `enable` in WAIT cycle 10 and re-raise → press 18 cycles after the new E0.
  - Drop `enable` during COOL → `busy` falls next cycle.
  - Assert `reset` during PRESS → all outputs 0 next cycle.
- Count saturation and clear:
  - 300 consecutive hits → `press_count` holds at 255.
  - Pulse `clear` → 0.
  - `clear` on the edge entering PRESS → `press_count` = 0, and `press` still pulses.

Source files
------------

// File: rtl/cpu_press_ctrl.sv
// Computer-player press sequencer: evaluates SW + Q >= 512 once per PERIOD-cycle
// interval, emits a one-cycle press on a hit, then holds off for COOL_CYCLES.
module cpu_press_ctrl #(
  parameter int PERIOD      = 16,
  parameter int COOL_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [8:0] Q,
  input  logic [8:0] SW,
  input  logic       clear,
  output logic       press,
  output logic       busy,
  output logic [7:0] press_count
);

  localparam int MAXC = (PERIOD > COOL_CYCLES) ? PERIOD : COOL_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] P_LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COOL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    EVAL  = 3'd2,
    PRESS = 3'd3,
    COOL  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      count_q, count_d;
  logic            press_q, busy_q;
  logic            hit;

  // Zero-extended 10-bit sum: its carry-out is the hit, so SW = 0 can never hit.
  assign hit = ({1'b0, SW} + {1'b0, Q}) >= 10'd512;

  // One counter serves both the interval (WAIT) and cooldown (COOL) phases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = WAIT;
          cnt_d   = '0;
        end
        WAIT: begin
          if (cnt_q == P_LAST) begin
            state_d = EVAL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        EVAL: begin
          state_d = hit ? PRESS : WAIT;
          cnt_d   = '0;
        end
        PRESS: begin
          state_d = COOL;
          cnt_d   = '0;
        end
        COOL: begin
          if (cnt_q == C_LAST) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Count is bumped on the edge entering PRESS; clear takes priority.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (state_q == EVAL && state_d == PRESS && count_q != 8'hFF) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      count_q <= '0;
      press_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      press_q <= (state_d == PRESS);
      busy_q  <= (state_d == PRESS) || (state_d == COOL);
    end
  end

  assign press       = press_q;
  assign busy        = busy_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_cpu_press_ctrl.sv
// Bench for cpu_press_ctrl: timeline model of eval/press/cooldown instants checked
// every cycle, plus directed literal checks of latency, spacing and counting.
module tb_cpu_press_ctrl;

  localparam int PERIOD = 16;
  localparam int COOL   = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [8:0] Q = 9'd0;
  logic [8:0] SW = 9'd0;
  logic       clear = 1'b0;
  logic       press, busy;
  logic [7:0] press_count;

  cpu_press_ctrl #(.PERIOD(PERIOD), .COOL_CYCLES(COOL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .Q(Q), .SW(SW), .clear(clear),
    .press(press), .busy(busy), .press_count(press_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;
  int npress = 0;

  // Model: k numbers the cycle following each rising edge; the model tracks when
  // the next evaluation falls, when the last press occurred and when busy ends.
  int k = 0;
  bit m_idle = 1'b1;
  int m_eval_at = -1000;
  int m_press_at = -1000;
  int m_busy_until = -1000;
  int m_count = 0;

  always @(posedge clk) begin
    k++;
    if (reset) begin
      m_idle = 1'b1;
      m_count = 0;
      m_eval_at = -1000;
      m_busy_until = -1000;
    end else begin
      if (!enable) begin
        m_idle = 1'b1;
        m_busy_until = -1000;
      end else if (m_idle) begin
        m_idle = 1'b0;
        m_eval_at = k + PERIOD;
      end else if (k - 1 == m_eval_at) begin
        if (int'(SW) + int'(Q) >= 512) begin
          m_press_at = k;
          m_busy_until = k + COOL;
          m_eval_at = k + COOL + PERIOD + 1;
          if (m_count < 255) m_count++;
        end else begin
          m_eval_at = k + PERIOD;
        end
      end
      if (clear) m_count = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic ep, eb;
      ep = !m_idle && (m_press_at == k);
      eb = !m_idle && (k >= m_press_at) && (k <= m_busy_until);
      vectors++;
      if (press !== ep || busy !== eb || press_count !== 8'(m_count)) begin
        miscompares++;
        $display("FAIL cycle %0d: press/busy/count got %0b/%0b/%0d, expected %0b/%0b/%0d",
                 k, press, busy, press_count, ep, eb, m_count);
      end
      if (press === 1'b1) npress++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_press(input int bound, output int kp, output bit ok);
    ok = 1'b0;
    kp = -1;
    for (int i = 0; i < bound; i++) begin
      cyc(1);
      if (press === 1'b1) begin
        ok = 1'b1;
        kp = k;
        break;
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e0, kp, kp2, n, base;
    bit ok;

    // Reset and idle with maximal operands
    SW = 9'd511; Q = 9'd511; reset = 1'b1; enable = 1'b0;
    cyc(1);
    chk_on = 1'b1;
    cyc(1);
    reset = 1'b0;
    base = npress;
    cyc(100);
    chk("idle_no_press", npress - base, 0);
    chk("idle_count", int'(press_count), 0);

    // First-press latency and busy width
    SW = 9'd2; Q = 9'd510; enable = 1'b1;
    e0 = k + 1;
    wait_press(40, kp, ok);
    chk("first_press_found", int'(ok), 1);
    chk("first_press_cycle", kp - e0 + 1, 18);
    chk("first_press_count", int'(press_count), 1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      cyc(1);
    end
    chk("busy_width", n, 33);
    chk("press_width_one", int'(press), 0);

    // Compare boundary: sum 511 never hits, 512 does
    Q = 9'd509;
    base = npress;
    cyc(500);
    chk("sum511_no_press", npress - base, 0);
    Q = 9'd510;
    wait_press(PERIOD + 4, kp, ok);
    chk("sum512_press", int'(ok), 1);
    SW = 9'd0; Q = 9'd511;
    base = npress;
    cyc(300);
    chk("sw0_no_press", npress - base, 0);

    // Back-to-back hits at SW = 511
    SW = 9'd511; Q = 9'd511;
    wait_press(60, kp, ok);
    wait_press(60, kp2, ok);
    chk("press_spacing", kp2 - kp, 50);
    Q = 9'd0;
    base = npress;
    cyc(200);
    chk("sw511_q0_no_press", npress - base, 0);

    // Enable dropped in WAIT cycle 10, then re-raised
    Q = 9'd511;
    enable = 1'b0;
    cyc(3);
    enable = 1'b1;
    cyc(10);
    enable = 1'b0;
    cyc(1);
    enable = 1'b1;
    e0 = k + 1;
    wait_press(40, kp, ok);
    chk("reenable_latency", kp - e0 + 1, 18);

    // Enable dropped during COOL
    cyc(5);
    chk("cool_busy", int'(busy), 1);
    enable = 1'b0;
    cyc(1);
    chk("cool_drop_busy", int'(busy), 0);

    // Reset asserted during PRESS
    enable = 1'b1;
    wait_press(40, kp, ok);
    chk("pre_reset_press", int'(ok), 1);
    reset = 1'b1;
    cyc(1);
    chk("reset_press", int'(press), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_count", int'(press_count), 0);
    reset = 1'b0;

    // Saturation after 300 hits, then clear
    n = 0;
    for (int i = 0; i < 300; i++) begin
      wait_press(60, kp, ok);
      if (ok) n++;
    end
    chk("hits_300", n, 300);
    chk("count_saturated", int'(press_count), 255);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("count_cleared", int'(press_count), 0);

    // Clear coinciding with the edge entering PRESS
    wait_press(60, kp, ok);
    chk("pre_clear_count", int'(press_count), 1);
    cyc(49);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clear_vs_inc_press", int'(press), 1);
    chk("clear_vs_inc_count", int'(press_count), 0);
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
